// File: rtl/multdiv_defs.sv
// rtl/multdiv_defs.sv - shared state encodings, default step counts and op codes for the mult/div sequencer
package multdiv_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int MULT_STEPS_DEF = 16;
    localparam int DIV_STEPS_DEF  = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/dffe_ref.sv
// rtl/dffe_ref.sv - reference enabled D flip-flop with asynchronous active-high clear
module dffe_ref (
    input  logic clk_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            q_o <= 1'b0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/multdiv_step_counter.sv
// rtl/multdiv_step_counter.sv - iteration counter from dffe_ref bits with ripple incrementer and terminal-count compare
module multdiv_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             sync_clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] carry;

    assign carry = {carry[CNT_W-2:0] & count_q[CNT_W-2:0], 1'b1};

    // synchronous clear takes priority over counting, so the cell enable covers both
    assign count_d = sync_clr_i ? '0 : (count_q ^ carry);

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        dffe_ref u_bit (
            .clk_i (clk_i),
            .clr_i (clr_i),
            .en_i  (en_i | sync_clr_i),
            .d_i   (count_d[i]),
            .q_o   (count_q[i])
        );
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - control FSM sequencing the iterative multiply/divide working-state register
module multdiv_sequencer
    import multdiv_defs::*;
#(
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF,
    parameter int CNT_W      = 6
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             state_en,
    output logic             state_load,
    output logic             op_div,
    output logic [CNT_W-1:0] step,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    seq_state_e state_q, state_d;
    logic       start_q;
    logic       start_div_q;
    logic       op_div_q, op_div_d;
    logic       exc_q, exc_d;
    logic       tc;
    logic [CNT_W-1:0] limit;

    // start pulses are captured first; the FSM acts on the captured copy one edge later
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            start_q     <= 1'b0;
            start_div_q <= 1'b0;
            state_q     <= ST_IDLE;
            op_div_q    <= OP_MULT;
            exc_q       <= 1'b0;
        end else begin
            start_q     <= ctrl_mult | ctrl_div;
            start_div_q <= ctrl_div & ~ctrl_mult;
            state_q     <= state_d;
            op_div_q    <= op_div_d;
            exc_q       <= exc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        exc_d    = exc_q;
        if (start_q) begin
            state_d  = ST_INIT;
            op_div_d = start_div_q ? OP_DIV : OP_MULT;
            exc_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_INIT: begin
                    if (op_div_q && divisor_zero) begin
                        exc_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tc) begin
                        state_d = ST_DONE;
                        if (!op_div_q) begin
                            exc_d = mult_ovf;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign limit = op_div_q ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MULT_STEPS - 1);

    // clearing on a pending start keeps step at 0 in INIT even after an abort from RUN
    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk_i      (clock),
        .clr_i      (clr),
        .sync_clr_i ((state_q != ST_RUN) | start_q),
        .en_i       ((state_q == ST_RUN) & ~tc),
        .limit_i    (limit),
        .count_o    (step),
        .tc_o       (tc)
    );

    assign state_en   = (state_q == ST_INIT) | (state_q == ST_RUN);
    assign state_load = (state_q == ST_INIT);
    assign busy       = (state_q == ST_INIT) | (state_q == ST_RUN);
    assign result_rdy = (state_q == ST_DONE);
    assign exception  = (state_q == ST_DONE) & exc_q;
    assign op_div     = op_div_q;

endmodule
